// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor, LSB first: one full adder and one carry flop
// sweep WIDTH operand bits, then the parallel result and flags are presented.
module serial_addsub_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    cnt_r;
  logic             mode_r;
  logic             carry_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic             bb_s;
  logic             sum_s;
  logic             c_next_s;
  logic             last_s;

  // Single full adder; subtraction inverts B and relies on the carry seed of 1.
  always_comb begin
    bb_s     = b_sr_r[0] ^ mode_r;
    sum_s    = a_sr_r[0] ^ bb_s ^ carry_r;
    c_next_s = (a_sr_r[0] & bb_s) | (a_sr_r[0] & carry_r) | (bb_s & carry_r);
    last_s   = (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_s = DONE_ST;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE_ST: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifters, carry flop, counter and registered outputs.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      a_sr_r      <= {WIDTH{1'b0}};
      b_sr_r      <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      mode_r      <= 1'b0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r      <= a_in;
            b_sr_r      <= b_in;
            mode_r      <= mode;
            carry_r     <= mode;
            cnt_r       <= {CW{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        SHIFT: begin
          result_r <= {sum_s, result_r[WIDTH-1:1]};
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r  <= c_next_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            // Overflow: carry into the MSB differs from carry out of it.
            carry_out_r <= c_next_s;
            overflow_r  <= carry_r ^ c_next_s;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        DONE_ST: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Directed bench for serial_addsub_n at WIDTH 4, 8 and 32 sharing one clock and reset.
module tb_serial_addsub_n;

  logic        clk = 1'b0;
  logic        clear_b;
  logic        mode;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic [2:0]  start_v;
  logic [3:0]  r4;
  logic [7:0]  r8;
  logic [31:0] r32;
  logic [2:0]  co_v;
  logic [2:0]  ov_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub_n #(.WIDTH(4)) u_w4 (
    .clk(clk), .clear_b(clear_b), .start(start_v[0]), .mode(mode),
    .a_in(a_drv[3:0]), .b_in(b_drv[3:0]), .result(r4),
    .carry_out(co_v[0]), .overflow(ov_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );
  serial_addsub_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .clear_b(clear_b), .start(start_v[1]), .mode(mode),
    .a_in(a_drv[7:0]), .b_in(b_drv[7:0]), .result(r8),
    .carry_out(co_v[1]), .overflow(ov_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );
  serial_addsub_n #(.WIDTH(32)) u_w32 (
    .clk(clk), .clear_b(clear_b), .start(start_v[2]), .mode(mode),
    .a_in(a_drv), .b_in(b_drv), .result(r32),
    .carry_out(co_v[2]), .overflow(ov_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] res_of(input int idx);
    case (idx)
      0:       return {28'd0, r4};
      1:       return {24'd0, r8};
      default: return r32;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: extended-width sum; overflow from operand/result sign pattern.
  task automatic model(input int w, input logic m, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v);
    longint unsigned msk, aa, bb, s;
    msk = (64'd1 << w) - 64'd1;
    aa  = {32'd0, a} & msk;
    bb  = (m ? ~{32'd0, b} : {32'd0, b}) & msk;
    s   = aa + bb + {63'd0, m};
    r   = 32'(s & msk);
    c   = s[w];
    v   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
  endtask

  task automatic run_op(input int idx, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic ev, input string tag);
    int cyc;
    @(negedge clk);
    mode = m; a_drv = a; b_drv = b; start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a_drv = ~a; b_drv = ~b; mode = ~m;
    check_eq({tag, "_busy"}, {31'd0, busy_v[idx]}, 32'd1);
    cyc = 0;
    while (!done_v[idx] && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, width_of(idx));
    check_eq({tag, "_res"}, res_of(idx), er);
    check_eq({tag, "_co"}, {31'd0, co_v[idx]}, {31'd0, ec});
    check_eq({tag, "_ov"}, {31'd0, ov_v[idx]}, {31'd0, ev});
    check_eq({tag, "_busy_off"}, {31'd0, busy_v[idx]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_1cyc"}, {31'd0, done_v[idx]}, 32'd0);
    check_eq({tag, "_hold"}, res_of(idx), er);
  endtask

  initial begin
    logic [31:0] er, ra, rb;
    logic        ec, ev, rm;
    logic [31:0] a_hist[16];
    logic [31:0] b_hist[16];
    logic        m_hist[16];
    int          rise0, rise1, done_e, overlap, cyc, done_seen;
    logic        prev_busy;
    logic [7:0]  first_res;

    clear_b = 1'b0; start_v = 3'b000; mode = 1'b0; a_drv = 32'd0; b_drv = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {r32, r8, r4, co_v, ov_v, busy_v, done_v}, 32'd0);
    check_eq("rst_r32", r32, 32'd0);
    clear_b = 1'b1;

    run_op(0, 1'b1, 32'h0A, 32'h03, 32'h7, 1'b1, 1'b1, "w4_sub_a_3");
    run_op(0, 1'b0, 32'h07, 32'h01, 32'h8, 1'b0, 1'b1, "w4_add_ovf");
    run_op(1, 1'b1, 32'h03, 32'h0A, 32'hF9, 1'b0, 1'b0, "w8_sub_borrow");
    run_op(1, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1, "w8_sub_ovf");
    run_op(1, 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, "w8_add_ovf");
    run_op(1, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0, "w8_add_wrap");

    // Start held high while operands churn: only IDLE samples count.
    @(negedge clk);
    a_drv = 32'h11; b_drv = 32'h22; mode = 1'b0; start_v[1] = 1'b1;
    a_hist[0] = 32'h11; b_hist[0] = 32'h22; m_hist[0] = 1'b0;
    rise0 = -1; rise1 = -1; done_e = -1; overlap = 0; prev_busy = 1'b0; first_res = 8'd0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy_v[1] && done_v[1]) overlap++;
      if (done_v[1] && done_e < 0) begin
        done_e = e;
        first_res = r8;
      end
      if (busy_v[1] && !prev_busy) begin
        if (rise0 < 0) rise0 = e;
        else if (rise1 < 0) rise1 = e;
      end
      prev_busy = busy_v[1];
      a_drv = $urandom; b_drv = $urandom; mode = 1'($urandom);
      a_hist[e + 1] = a_drv; b_hist[e + 1] = b_drv; m_hist[e + 1] = mode;
    end
    start_v[1] = 1'b0;
    check_eq("hold_first_rise", rise0, 0);
    check_eq("hold_done_edge", done_e, 8);
    check_eq("hold_restart", rise1, 10);
    check_eq("hold_res", {24'd0, first_res}, 32'h33);
    if (rise1 >= 0) begin
      model(8, m_hist[rise1], a_hist[rise1], b_hist[rise1], er, ec, ev);
      done_seen = 0;
      for (int e = 0; e < 20 && done_seen == 0; e++) begin
        if (done_v[1]) done_seen = 1;
        else begin
          @(posedge clk);
          @(negedge clk);
          if (busy_v[1] && done_v[1]) overlap++;
        end
      end
      check_eq("hold2_done", done_seen, 1);
      check_eq("hold2_res", {24'd0, r8}, er);
      check_eq("hold2_co", {31'd0, co_v[1]}, {31'd0, ec});
    end
    check_eq("hold_overlap", overlap, 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    a_drv = 32'h55; b_drv = 32'h0F; mode = 1'b0; start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    check_eq("midrst_busy_pre", {31'd0, busy_v[1]}, 32'd1);
    #2 clear_b = 1'b0;
    #1;
    check_eq("midrst_outs", {r8, co_v[1], ov_v[1], busy_v[1], done_v[1]}, 32'd0);
    cyc = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (done_v[1]) cyc++;
      if (e == 3) clear_b = 1'b1;
    end
    check_eq("midrst_no_done", cyc, 0);
    run_op(1, 1'b0, 32'h55, 32'h0F, 32'h64, 1'b0, 1'b0, "w8_after_rst");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rm = 1'(i);
      model(32, rm, ra, rb, er, ec, ev);
      run_op(2, rm, ra, rb, er, ec, ev, $sformatf("w32_rand%0d", i));
    end
    run_op(2, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, "w32_sub_ovf");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t limit reached", $time);
    $fatal(1);
  end

endmodule
